fila_palavras: RTL and testbench
================================

// Module: fila_palavras
// PURPOSE
//  Byte queue that sits directly downstream of the deserializer. It accepts each completed
//  8-bit word (deserializer data_ready/data_out), acknowledges it on ack_out (wired to the
//  deserializer ack_in), and stores it in a circular buffer. A consumer drains the buffer
//  through dequeue_in. When the queue is full it withholds ack, which stalls the deserializer.
// PARAMETERS
//  DEPTH  8  number of word entries; power of two, >= 2
//  WIDTH  8  word width in bits
// PORTS
//  clock_100KHz  in   1               single clock; all state updates on its rising edge
//  reset         in   1               asynchronous, active-low; 0 clears all state immediately
//  data_in       in   WIDTH           word from deserializer data_out
//  enqueue_in    in   1               from deserializer data_ready; word on data_in is valid
//  ack_out       out  1               to deserializer ack_in; 1-cycle pulse per accepted word
//  dequeue_in    in   1               consumer request to pop the oldest word
//  data_out      out  WIDTH           last popped word; registered; held until next pop
//  data_valid    out  1               1-cycle pulse, coincident with each data_out update
//  len_out       out  $clog2(DEPTH)+1 current occupancy, 0..DEPTH
//  full_out      out  1               len_out == DEPTH
//  empty_out     out  1               len_out == 0
// BEHAVIOUR
//  Reset (reset==0, async): wr_ptr=rd_ptr=0, len=0, state=IDLE, ack_out=0, data_out=0,
//   data_valid=0, full_out=0, empty_out=1. Memory contents need not be cleared. Asserting
//   reset mid-operation discards all stored words and any pending ack.
//  Enqueue FSM, 2 states:
//   IDLE: if enqueue_in && !full -> mem[wr_ptr]<=data_in, wr_ptr++, ack_out<=1, go to ACK.
//         if enqueue_in && full  -> no write, ack_out stays 0, stay IDLE (back-pressure).
//   ACK : ack_out<=0 and return to IDLE. enqueue_in is ignored here, because the
//         deserializer drops data_ready on the same edge that samples ack; this prevents a
//         double write.
//   Latency: accepted word -> ack_out high on the next edge, exactly 1 cycle wide.
//   Max enqueue rate: 1 word per 2 cycles.
//  Dequeue (independent of the FSM): if dequeue_in && !empty -> data_out<=mem[rd_ptr],
//   rd_ptr++, data_valid<=1 for one cycle. If dequeue_in && empty -> ignored: data_out
//   holds and data_valid=0.
//  Full/empty are evaluated on the occupancy before the edge. This means:
//   - Full + simultaneous dequeue: the enqueue is still refused that cycle. It is retried
//     next cycle because enqueue_in stays high.
//   - Empty + simultaneous enqueue: the dequeue is refused. There is no bypass path.
//  Occupancy: len += accepted_enq - accepted_deq. If both are accepted in the same cycle,
//   len is unchanged. len never exceeds DEPTH and never goes below 0.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally (DEPTH-1 -> 0).
//  full_out, empty_out and len_out are registered and consistent with len after every edge.
//  Words are popped in exactly the order they were accepted (FIFO).
// TESTING
//  1 Reset: hold reset=0, then release -> empty_out=1, full_out=0, len_out=0, ack_out=0,
//    data_out=8'h00.
//  2 Single word: enqueue_in=1 with data_in=8'h41 for 2 cycles -> ack_out is exactly one
//    1-cycle pulse and len_out=1. Then dequeue_in for 1 cycle -> data_out=8'h41,
//    data_valid pulses once, empty_out=1.
//  3 Fill/back-pressure: push 8'h01..8'h08 -> full_out=1, len_out=8. Hold enqueue_in=1
//    with 8'h09 -> no ack_out for 10 cycles. Pop once -> 8'h09 is acked on the following
//    IDLE cycle, and the pop returns 8'h01.
//  4 Wrap: push 6, pop 6, push 5, pop 5 (values 8'hA0+i) -> popped values match in order,
//    pointers wrap, and len_out returns to 0.
//  5 Simultaneous: len=3, enqueue and dequeue accepted on the same edge -> len_out stays 3
//    and correct FIFO order is kept. When empty, enqueue+dequeue on the same edge ->
//    len_out=1 and data_valid=0.
//  6 Mid-op reset: len=4 with ack_out high, pulse reset=0 -> all outputs at their reset
//    values immediately, and the next pop after refill returns the newly written data.

Source files
------------

// File: rtl/fila_palavras.sv
`default_nettype none
// ============================================================================
//  Module   : fila_palavras
//  Brief    : Circular word queue downstream of the deserializer. Accepts one
//             word per enqueue handshake (ack pulse), withholds ack when full,
//             and pops the oldest word on request into a registered output.
//  Revision : 1.0 - initial release
// ============================================================================
module fila_palavras #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clock_100KHz,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     enqueue_in,
   output logic                     ack_out,
   input  logic                     dequeue_in,
   output logic [WIDTH-1:0]         data_out,
   output logic                     data_valid,
   output logic [$clog2(DEPTH):0]   len_out,
   output logic                     full_out,
   output logic                     empty_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              ack_next;
   logic              enq_ok;
   logic              deq_ok;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     len_next;
   logic [WIDTH-1:0]  mem [DEPTH];

   // Enqueue FSM decode: accept only in IDLE and only when not already full;
   // the ACK state ignores enqueue_in so a lingering data_ready cannot write twice.
   always_comb begin
      state_next = state;
      ack_next   = 1'b0;
      enq_ok     = 1'b0;
      case (state)
         IDLE: begin
            if (enqueue_in && !full_out) begin
               enq_ok     = 1'b1;
               ack_next   = 1'b1;
               state_next = ACK;
            end
         end
         ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Pops are refused on the pre-edge empty flag: no bypass from a same-cycle write.
   assign deq_ok = dequeue_in && !empty_out;

   // Occupancy update; simultaneous accepted push and pop leave it unchanged.
   always_comb begin
      len_next = len_out;
      case ({enq_ok, deq_ok})
         2'b10:   len_next = len_out + LW'(1);
         2'b01:   len_next = len_out - LW'(1);
         default: len_next = len_out;
      endcase
   end

   // Control state, pointers, flags and output registers.
   always_ff @(posedge clock_100KHz or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ack_out    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         len_out    <= '0;
         full_out   <= 1'b0;
         empty_out  <= 1'b1;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         state      <= state_next;
         ack_out    <= ack_next;
         len_out    <= len_next;
         full_out   <= (len_next == LW'(DEPTH));
         empty_out  <= (len_next == '0);
         data_valid <= deq_ok;
         if (enq_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (deq_ok) begin
            rd_ptr   <= rd_ptr + AW'(1);
            data_out <= mem[rd_ptr];
         end
      end
   end

   // Storage array; contents are don't-care after reset, so it carries no reset.
   always_ff @(posedge clock_100KHz) begin
      if (enq_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fila_palavras.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fila_palavras
//  Brief    : Directed self-checking bench for the fila_palavras word queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fila_palavras;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  data_in;
   logic        enqueue_in;
   logic        ack_out;
   logic        dequeue_in;
   logic [7:0]  data_out;
   logic        data_valid;
   logic [3:0]  len_out;
   logic        full_out;
   logic        empty_out;

   int n_compared   = 0;
   int n_mismatched = 0;
   int ack_count;

   fila_palavras #(.DEPTH(8), .WIDTH(8)) dut (
      .clock_100KHz (clk),
      .reset        (reset),
      .data_in      (data_in),
      .enqueue_in   (enqueue_in),
      .ack_out      (ack_out),
      .dequeue_in   (dequeue_in),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .len_out      (len_out),
      .full_out     (full_out),
      .empty_out    (empty_out)
   );

   always #5 clk = ~clk;

   // Single comparison point for every check in the bench.
   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle 1 time unit past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full enqueue handshake: request, see the ack pulse, wait out the ACK state.
   task automatic push(input logic [7:0] v);
      enqueue_in = 1'b1;
      data_in    = v;
      tick();
      check_value("push_ack", ack_out, 1);
      enqueue_in = 1'b0;
      tick();
      check_value("push_ack_drop", ack_out, 0);
   endtask

   // Single pop, comparing the popped word with the expected one.
   task automatic pop_expect(input string tag, input logic [7:0] exp);
      dequeue_in = 1'b1;
      tick();
      dequeue_in = 1'b0;
      check_value(tag, data_out, exp);
      check_value("pop_valid", data_valid, 1);
   endtask

   initial begin
      reset      = 1'b0;
      data_in    = 8'h00;
      enqueue_in = 1'b0;
      dequeue_in = 1'b0;

      // ---- 1 Reset ----
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check_value("rst_empty", empty_out, 1);
      check_value("rst_full",  full_out, 0);
      check_value("rst_len",   len_out, 0);
      check_value("rst_ack",   ack_out, 0);
      check_value("rst_data",  data_out, 8'h00);
      check_value("rst_valid", data_valid, 0);

      // ---- 2 Single word, enqueue held for two cycles ----
      enqueue_in = 1'b1;
      data_in    = 8'h41;
      ack_count  = 0;
      tick();
      ack_count += int'(ack_out);
      check_value("single_ack_hi", ack_out, 1);
      tick();
      ack_count += int'(ack_out);
      enqueue_in = 1'b0;
      tick();
      ack_count += int'(ack_out);
      check_value("single_ack_count", ack_count, 1);
      check_value("single_len", len_out, 1);
      pop_expect("single_pop", 8'h41);
      check_value("single_empty", empty_out, 1);
      tick();
      check_value("single_valid_drop", data_valid, 0);

      // ---- 3 Fill and back-pressure ----
      for (int i = 1; i <= 8; i++) push(8'(i));
      check_value("fill_full", full_out, 1);
      check_value("fill_len", len_out, 8);
      enqueue_in = 1'b1;
      data_in    = 8'h09;
      ack_count  = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         ack_count += int'(ack_out);
      end
      check_value("bp_no_ack", ack_count, 0);
      dequeue_in = 1'b1;
      tick();
      dequeue_in = 1'b0;
      check_value("bp_pop_data", data_out, 8'h01);
      check_value("bp_pop_valid", data_valid, 1);
      check_value("bp_refused_ack", ack_out, 0);
      check_value("bp_len7", len_out, 7);
      tick();
      check_value("bp_retry_ack", ack_out, 1);
      check_value("bp_len8", len_out, 8);
      check_value("bp_full_again", full_out, 1);
      enqueue_in = 1'b0;
      tick();
      for (int i = 2; i <= 9; i++) pop_expect("drain_order", 8'(i));
      check_value("drain_empty", empty_out, 1);
      check_value("drain_len", len_out, 0);

      // ---- 4 Pointer wrap ----
      for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
      for (int i = 0; i < 6; i++) pop_expect("wrap_a", 8'hA0 + 8'(i));
      for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
      check_value("wrap_len5", len_out, 5);
      for (int i = 0; i < 5; i++) pop_expect("wrap_b", 8'hA0 + 8'(i));
      check_value("wrap_len0", len_out, 0);
      check_value("wrap_empty", empty_out, 1);

      // ---- 5 Simultaneous enqueue and dequeue ----
      push(8'hB0); push(8'hB1); push(8'hB2);
      enqueue_in = 1'b1;
      dequeue_in = 1'b1;
      data_in    = 8'hB3;
      tick();
      enqueue_in = 1'b0;
      dequeue_in = 1'b0;
      check_value("sim_ack", ack_out, 1);
      check_value("sim_pop", data_out, 8'hB0);
      check_value("sim_len3", len_out, 3);
      tick();
      pop_expect("sim_order", 8'hB1);
      pop_expect("sim_order", 8'hB2);
      pop_expect("sim_order", 8'hB3);
      check_value("sim_empty", empty_out, 1);
      enqueue_in = 1'b1;
      dequeue_in = 1'b1;
      data_in    = 8'hC0;
      tick();
      enqueue_in = 1'b0;
      dequeue_in = 1'b0;
      check_value("empty_both_len", len_out, 1);
      check_value("empty_both_valid", data_valid, 0);
      check_value("empty_both_hold", data_out, 8'hB3);
      tick();
      pop_expect("empty_both_pop", 8'hC0);

      // ---- 6 Mid-operation reset ----
      push(8'hD0); push(8'hD1); push(8'hD2);
      enqueue_in = 1'b1;
      data_in    = 8'hD3;
      tick();
      check_value("mid_ack_hi", ack_out, 1);
      check_value("mid_len4", len_out, 4);
      reset = 1'b0;
      #1;
      check_value("mid_rst_ack", ack_out, 0);
      check_value("mid_rst_len", len_out, 0);
      check_value("mid_rst_empty", empty_out, 1);
      check_value("mid_rst_full", full_out, 0);
      check_value("mid_rst_data", data_out, 8'h00);
      check_value("mid_rst_valid", data_valid, 0);
      enqueue_in = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      push(8'hE0); push(8'hE1);
      pop_expect("refill_pop", 8'hE0);
      pop_expect("refill_pop", 8'hE1);
      check_value("refill_empty", empty_out, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
`default_nettype wire
